// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, interrupts and mret, writes mepc/mcause and redirects the PC.
// Optional TRAP_VECTORED_EN: interrupts jump to base + 4*cause when mtvec mode is vectored.
module trap_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CSR_AW = 12,
  parameter int unsigned EXP_CW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              exp_i,
  input  logic [EXP_CW-1:0] exp_code_i,
  input  logic              mret_i,
  input  logic              ext_irq_i,
  input  logic              sft_irq_i,
  input  logic              tmr_irq_i,
  input  logic              meie_i,
  input  logic              msie_i,
  input  logic              mtie_i,
  input  logic              glb_irq_i,
  input  logic [ADDR_W-1:0] mtvec_i,
  input  logic [ADDR_W-1:0] mepc_i,
  output logic              hold_o,
  output logic              flush_o,
  output logic              jump_ena_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              csr_wen_o,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic [ADDR_W-1:0] csr_val_o,
  output logic              irq_src_o,
  output logic              exp_src_o,
  output logic              mret_ena_o
);

  localparam logic [CSR_AW-1:0] MepcAddr   = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] McauseAddr = CSR_AW'(12'h342);

  typedef enum logic [2:0] {
    StIdle, StWrEpc, StWrCause, StNotify, StJump, StMret, StMretJump
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cause_q;
  logic              is_irq_q;
  logic              hold_q, flush_q, jump_ena_q, csr_wen_q;
  logic              irq_src_q, exp_src_q, mret_ena_q;
  logic [ADDR_W-1:0] jump_addr_q, csr_val_q;
  logic [CSR_AW-1:0] csr_addr_q;

  logic              ext_pend, sft_pend, tmr_pend, irq_pend, trap, accept;
  logic [ADDR_W-1:0] cause_d, base_addr, vec_addr;

  assign ext_pend = glb_irq_i & ext_irq_i & meie_i;
  assign sft_pend = glb_irq_i & sft_irq_i & msie_i;
  assign tmr_pend = glb_irq_i & tmr_irq_i & mtie_i;
  assign irq_pend = ext_pend | sft_pend | tmr_pend;
  assign trap     = exp_i | irq_pend;
  // Gated by rst so hold stays low while reset is asserted.
  assign accept   = ~rst & (state_q == StIdle) & instr_valid_i & (trap | mret_i);

  always_comb begin
    cause_d = '0;
    if (exp_i) begin
      cause_d[EXP_CW-1:0] = exp_code_i;
    end else if (ext_pend) begin
      cause_d = {1'b1, (ADDR_W-1)'(11)};
    end else if (sft_pend) begin
      cause_d = {1'b1, (ADDR_W-1)'(3)};
    end else begin
      cause_d = {1'b1, (ADDR_W-1)'(7)};
    end
  end

  assign base_addr = {mtvec_i[ADDR_W-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign vec_addr = (mtvec_i[1:0] == 2'b01 && is_irq_q) ?
                    base_addr + ADDR_W'({cause_q[3:0], 2'b00}) : base_addr;
`else
  logic unused_mode;
  assign unused_mode = ^mtvec_i[1:0];
  assign vec_addr    = base_addr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cause_q     <= '0;
      is_irq_q    <= 1'b0;
      hold_q      <= 1'b0;
      flush_q     <= 1'b0;
      jump_ena_q  <= 1'b0;
      jump_addr_q <= '0;
      csr_wen_q   <= 1'b0;
      csr_addr_q  <= '0;
      csr_val_q   <= '0;
      irq_src_q   <= 1'b0;
      exp_src_q   <= 1'b0;
      mret_ena_q  <= 1'b0;
    end else begin
      hold_q      <= 1'b0;
      flush_q     <= 1'b0;
      jump_ena_q  <= 1'b0;
      jump_addr_q <= '0;
      csr_wen_q   <= 1'b0;
      csr_addr_q  <= '0;
      csr_val_q   <= '0;
      irq_src_q   <= 1'b0;
      exp_src_q   <= 1'b0;
      mret_ena_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            hold_q <= 1'b1;
            if (trap) begin
              cause_q    <= cause_d;
              is_irq_q   <= ~exp_i;
              state_q    <= StWrEpc;
              csr_wen_q  <= 1'b1;
              csr_addr_q <= MepcAddr;
              csr_val_q  <= pc_i;
            end else begin
              state_q    <= StMret;
              mret_ena_q <= 1'b1;
            end
          end
        end
        StWrEpc: begin
          state_q    <= StWrCause;
          hold_q     <= 1'b1;
          csr_wen_q  <= 1'b1;
          csr_addr_q <= McauseAddr;
          csr_val_q  <= cause_q;
        end
        StWrCause: begin
          state_q   <= StNotify;
          hold_q    <= 1'b1;
          irq_src_q <= is_irq_q;
          exp_src_q <= ~is_irq_q;
        end
        StNotify: begin
          state_q     <= StJump;
          hold_q      <= 1'b1;
          flush_q     <= 1'b1;
          jump_ena_q  <= 1'b1;
          jump_addr_q <= vec_addr;
        end
        StMret: begin
          state_q     <= StMretJump;
          hold_q      <= 1'b1;
          flush_q     <= 1'b1;
          jump_ena_q  <= 1'b1;
          jump_addr_q <= mepc_i;
        end
        StJump, StMretJump: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hold_o      = hold_q | accept;
  assign flush_o     = flush_q;
  assign jump_ena_o  = jump_ena_q;
  assign jump_addr_o = jump_addr_q;
  assign csr_wen_o   = csr_wen_q;
  assign csr_addr_o  = csr_addr_q;
  assign csr_val_o   = csr_val_q;
  assign irq_src_o   = irq_src_q;
  assign exp_src_o   = exp_src_q;
  assign mret_ena_o  = mret_ena_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: per-cycle expected output vectors queued at stimulus time.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid_i, exp_i, mret_i, ext_irq_i, sft_irq_i, tmr_irq_i;
  logic        meie_i, msie_i, mtie_i, glb_irq_i;
  logic [31:0] pc_i, mtvec_i, mepc_i;
  logic [3:0]  exp_code_i;
  logic        hold_o, flush_o, jump_ena_o, csr_wen_o, irq_src_o, exp_src_o, mret_ena_o;
  logic [31:0] jump_addr_o, csr_val_o;
  logic [11:0] csr_addr_o;

  typedef struct packed {
    logic        hold;
    logic        flush;
    logic        jump_ena;
    logic [31:0] jump_addr;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_val;
    logic        irq_src;
    logic        exp_src;
    logic        mret_ena;
  } obs_t;

  obs_t got;
  obs_t exp_q[$];
  int   n_total = 0;
  int   n_bad = 0;

  assign got = {hold_o, flush_o, jump_ena_o, jump_addr_o, csr_wen_o, csr_addr_o, csr_val_o,
                irq_src_o, exp_src_o, mret_ena_o};

  trap_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid_i(instr_valid_i), .pc_i(pc_i), .exp_i(exp_i),
    .exp_code_i(exp_code_i), .mret_i(mret_i), .ext_irq_i(ext_irq_i), .sft_irq_i(sft_irq_i),
    .tmr_irq_i(tmr_irq_i), .meie_i(meie_i), .msie_i(msie_i), .mtie_i(mtie_i),
    .glb_irq_i(glb_irq_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .hold_o(hold_o),
    .flush_o(flush_o), .jump_ena_o(jump_ena_o), .jump_addr_o(jump_addr_o),
    .csr_wen_o(csr_wen_o), .csr_addr_o(csr_addr_o), .csr_val_o(csr_val_o),
    .irq_src_o(irq_src_o), .exp_src_o(exp_src_o), .mret_ena_o(mret_ena_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input obs_t obs, input obs_t want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, want);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic e,
                        input logic [3:0] code, input logic m, input logic ext,
                        input logic sft, input logic tmr, input logic glb);
    instr_valid_i = v; pc_i = pc; exp_i = e; exp_code_i = code; mret_i = m;
    ext_irq_i = ext; sft_irq_i = sft; tmr_irq_i = tmr; glb_irq_i = glb;
  endtask

  task automatic clear_in();
    set_in(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause,
                           input logic irq, input logic [31:0] target);
    obs_t o;
    o = '0; o.hold = 1'b1; exp_q.push_back(o);
    o = '0; o.hold = 1'b1; o.csr_wen = 1'b1; o.csr_addr = 12'h341; o.csr_val = pc;
    exp_q.push_back(o);
    o = '0; o.hold = 1'b1; o.csr_wen = 1'b1; o.csr_addr = 12'h342; o.csr_val = cause;
    exp_q.push_back(o);
    o = '0; o.hold = 1'b1; o.irq_src = irq; o.exp_src = ~irq; exp_q.push_back(o);
    o = '0; o.hold = 1'b1; o.flush = 1'b1; o.jump_ena = 1'b1; o.jump_addr = target;
    exp_q.push_back(o);
    exp_q.push_back('0);
  endtask

  task automatic push_mret(input logic [31:0] mepc);
    obs_t o;
    o = '0; o.hold = 1'b1; exp_q.push_back(o);
    o = '0; o.hold = 1'b1; o.mret_ena = 1'b1; exp_q.push_back(o);
    o = '0; o.hold = 1'b1; o.flush = 1'b1; o.jump_ena = 1'b1; o.jump_addr = mepc;
    exp_q.push_back(o);
    exp_q.push_back('0);
  endtask

  // Inputs are applied just after a posedge; the first pop is cycle T.
  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check_val($sformatf("%s[%0d]", tag, k), got, exp_q.pop_front());
      k++;
      @(posedge clk);
      #1 clear_in();
    end
  endtask

  initial begin
    rst = 1'b1;
    meie_i = 1'b1; msie_i = 1'b1; mtie_i = 1'b1;
    mtvec_i = 32'h200; mepc_i = 32'h0;
    clear_in();
    repeat (2) @(posedge clk);
    #1 set_in(1'b1, 32'h80, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check_val("reset_state", got, '0);
    @(posedge clk);
    #1 rst = 1'b0; clear_in();

    set_in(1'b1, 32'h100, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_trap(32'h100, 32'h0000000B, 1'b0, 32'h200);
    drain("ecall");

    set_in(1'b1, 32'h40, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    push_trap(32'h40, 32'h80000007, 1'b1, 32'h200);
    drain("timer");

    set_in(1'b1, 32'h40, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back('0);
    exp_q.push_back('0);
    drain("timer_glb_off");

    set_in(1'b1, 32'h48, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    push_trap(32'h48, 32'h00000002, 1'b0, 32'h200);
    drain("prio_exc");

    set_in(1'b1, 32'h4C, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    push_trap(32'h4C, 32'h8000000B, 1'b1, 32'h200);
    drain("prio_ext");

    mepc_i = 32'h144;
    set_in(1'b1, 32'h50, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_mret(32'h144);
    drain("mret");

    set_in(1'b1, 32'h300, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    push_trap(32'h300, 32'h80000003, 1'b1, 32'h200);
    drain("mret_sft");

    set_in(1'b0, 32'h60, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_q.push_back('0);
    exp_q.push_back('0);
    drain("no_valid");

    // Reset lands in WR_CAUSE; nothing may follow it.
    set_in(1'b1, 32'h500, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_trap(32'h500, 32'h3, 1'b0, 32'h200);
    void'(exp_q.pop_back()); void'(exp_q.pop_back()); void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    drain("rst_pre");
    #1 rst = 1'b1;
    #1 check_val("rst_mid", got, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val($sformatf("rst_quiet[%0d]", i), got, '0);
    end
    @(posedge clk);
    #1 set_in(1'b1, 32'h504, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_trap(32'h504, 32'h2, 1'b0, 32'h200);
    drain("post_rst");

    mtvec_i = 32'h201;
    set_in(1'b1, 32'h600, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef TRAP_VECTORED_EN
    push_trap(32'h600, 32'h8000000B, 1'b1, 32'h22C);
`else
    push_trap(32'h600, 32'h8000000B, 1'b1, 32'h200);
`endif
    drain("vec_ext");

    set_in(1'b1, 32'h604, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_trap(32'h604, 32'h0000000B, 1'b0, 32'h200);
    drain("vec_exc");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
